// File: rtl/ms_delay_timer.sv
// Programmable millisecond delay timer driven by the shared 1 ms prescaler tick.
// Owns the prescaler enable/reset so every delay starts on a clean millisecond boundary.
module ms_delay_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_delay_ms,
    input  logic         i_abort,
    input  logic         i_onems,
    output logic         o_tick_en,
    output logic         o_presc_rst_n,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_aborted,
    output logic [W-1:0] o_remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    state_t       r_state;
    logic         r_tick_en;
    logic         r_presc_rst_n;
    logic         r_busy;
    logic         r_done;
    logic         r_aborted;
    logic [W-1:0] r_remaining;

    // Abort outranks the terminal tick, which outranks a new start.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= IDLE;
            r_tick_en     <= 1'b0;
            r_presc_rst_n <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_remaining   <= ZERO;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        if (i_delay_ms != ZERO) begin
                            r_state       <= ARM;
                            r_remaining   <= i_delay_ms;
                            r_busy        <= 1'b1;
                            r_tick_en     <= 1'b1;
                            r_presc_rst_n <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ARM, RUN: begin
                    if (i_abort) begin
                        r_state       <= IDLE;
                        r_aborted     <= 1'b1;
                        r_remaining   <= ZERO;
                        r_busy        <= 1'b0;
                        r_tick_en     <= 1'b0;
                        r_presc_rst_n <= 1'b1;
                    end else if (r_state == ARM) begin
                        // The prescaler is held in reset for exactly this one cycle.
                        r_state       <= RUN;
                        r_presc_rst_n <= 1'b1;
                    end else if (i_onems) begin
                        if (r_remaining > ONE) begin
                            r_remaining <= r_remaining - ONE;
                        end else begin
                            r_state     <= DONE;
                            r_remaining <= ZERO;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_tick_en   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tick_en     = r_tick_en;
    assign o_presc_rst_n = r_presc_rst_n;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_remaining   = r_remaining;

endmodule

// File: doc/ms_delay_timer.md
# ms_delay_timer

Programmable millisecond delay timer that consumes the 1 ms tick from the LFSR prescaler. On a start request it clears and enables the prescaler, counts `delay_ms` tick pulses, and reports completion with a one-cycle `done` pulse. It sits between control FSMs that need timed waits and the shared 1 ms LFSR prescaler, which it owns via `tick_en` / `presc_rst_n`.

## Interface
- `W`, 10, width of the delay and remaining-count fields (max delay 2^W−1 ms)
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  request a delay; sampled every cycle, accepted only in IDLE or DONE
- `delay_ms`  in  W  delay length in ms; sampled only in the cycle `start` is accepted
- `abort`  in  1  cancel a delay in progress
- `onems`  in  1  1 ms tick from the prescaler (one-cycle pulse)
- `tick_en`  out  1  enable to the prescaler
- `presc_rst_n`  out  1  active-low synchronous reset to the prescaler
- `busy`  out  1  delay in progress (ARM or RUN)
- `done`  out  1  one-cycle pulse on normal completion
- `aborted`  out  1  one-cycle pulse on abort
- `remaining`  out  W  ms left in the current delay

## Operation
- All outputs registered. Reset values: `tick_en`=0, `presc_rst_n`=1, `busy`=0, `done`=0, `aborted`=0, `remaining`=0, state IDLE.
- States: IDLE, ARM, RUN, DONE.
- IDLE/DONE + `start`, `delay_ms`=N>0: go to ARM. `remaining`=N, `busy`=1, `tick_en`=1, `presc_rst_n`=0.
- IDLE/DONE + `start`, N=0: go to DONE. `done`=1, `busy`=0, prescaler untouched.
- ARM, exactly one cycle: `presc_rst_n`=0 and `onems` ignored. Go to RUN with `presc_rst_n`=1.
- RUN + `onems`=1 with `remaining`>1: decrement `remaining`.
- RUN + `onems`=1 with `remaining`=1: go to DONE. `remaining`=0, `done`=1, `busy`=0, `tick_en`=0.
- DONE lasts one cycle; then IDLE, `done`=0, unless `start` is accepted.
- ARM/RUN + `abort`: go to IDLE. `aborted`=1 for one cycle, `remaining`=0, `busy`=0, `tick_en`=0, `presc_rst_n`=1, no `done`.
- Priority in a cycle: `rst` > `abort` > terminal `onems` > `start`.
- `start` while busy is ignored; it does not restart the delay.
- `abort` in IDLE/DONE is ignored; no `aborted` pulse.
- `onems` outside RUN is ignored.
- `remaining` never underflows. The decrement is W-bit and guarded by the `remaining`>1 check.

## Timing
- `start` accepted at edge of cycle T: ARM during T+1; prescaler sees reset at edge T+2; RUN from T+2.
- Completion: `done`=1 in the cycle after the cycle in which the N-th `onems` is sampled high in RUN.
- With a prescaler period of P cycles, total latency from `start` to `done` is about 2+N·P cycles. Because of the ARM clear, the first interval is a full P; no partial first millisecond.
- Back-to-back: `start` asserted during the `done` cycle is accepted; ARM follows with no idle gap.
- `rst` low mid-delay returns to reset values at the next edge; no `done` or `aborted` pulse.
- `onems` is assumed to be a single-cycle pulse. A held-high `onems` decrements once per cycle.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → all outputs at reset values, state IDLE; release → idle until a new `start`.
- Normal delay: W=10, `delay_ms`=3, stub `onems` every 20 cycles → `presc_rst_n` low exactly 1 cycle (T+1); `remaining` goes 3→2→1→0; `done` high 1 cycle after the 3rd tick; `busy` and `tick_en` drop in that same cycle.
- Zero delay: `delay_ms`=0 → `done`=1 at T+1; `busy` never high; `presc_rst_n` stays 1; `tick_en` stays 0.
- Abort: `delay_ms`=5, `abort` after 2 ticks → `aborted` pulse, `remaining`=0, no `done`. Abort coinciding with the final `onems` (`remaining`=1) → `aborted` only, no `done`.
- Ignored start and re-arm: `start` with `delay_ms`=7 pulsed during RUN of a 4 ms delay → completes after 4 ticks. `start` with `delay_ms`=2 asserted in the `done` cycle → ARM next cycle, `remaining`=2.
- Max value: `delay_ms`=1023 → exactly 1023 ticks to `done`; no wrap of `remaining`.
